// File: rtl/rv_pkg.sv
// Shared RV32 writeback definitions: opcodes, load funct3 codes, stage state.
package rv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_t;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_R, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension; flags misaligned or illegal funct3.
// Purely combinational, no backpressure.
module load_align
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        half_sel = word[15:0];
        case (offset)
            2'd0: begin byte_sel = word[7:0];   half_sel = word[15:0];  end
            2'd1: begin byte_sel = word[15:8];  half_sel = word[23:8];  end
            2'd2: begin byte_sel = word[23:16]; half_sel = word[31:16]; end
            default: begin byte_sel = word[31:24]; half_sel = word[31:16]; end
        endcase
    end

    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data       = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = (offset == 2'd3);
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = (offset == 2'd3);
            end
            F3_LW: begin
                data       = word;
                misaligned = (offset != 2'd0);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU / PC+4 / load data and drives the register-file write port.
// Latency 1 for non-loads; in_ready drops while a load waits for mem_rvalid or times out.
module wb_stage
    import rv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            misalign_err,
    output logic            timeout_err
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    wb_state_t       state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [2:0]      lf3_q, lf3_d;
    logic [4:0]      lrd_q, lrd_d;
    logic [1:0]      loff_q, loff_d;
    logic            mem_req_d, rf_we_d, mis_d, to_d;
    logic [XLEN-1:0] mem_addr_d, wdata_d;
    logic [4:0]      waddr_d;

    logic [2:0]      al_f3;
    logic [1:0]      al_off;
    logic [XLEN-1:0] al_data;
    logic            al_mis;

    // One aligner serves both the accept-time legality check and the response extraction.
    assign al_f3  = (state_q == WAIT) ? lf3_q  : funct3;
    assign al_off = (state_q == WAIT) ? loff_q : alu_result[1:0];

    load_align #(.XLEN(XLEN)) u_align (
        .word       (mem_rdata),
        .offset     (al_off),
        .funct3     (al_f3),
        .data       (al_data),
        .misaligned (al_mis)
    );

    assign in_ready = rst_n && (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lf3_d      = lf3_q;
        lrd_d      = lrd_q;
        loff_d     = loff_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr;
        rf_we_d    = 1'b0;
        waddr_d    = rf_waddr;
        wdata_d    = rf_wdata;
        mis_d      = 1'b0;
        to_d       = timeout_err;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (opcode == OP_LOAD) begin
                        if (al_mis) begin
                            mis_d = 1'b1;
                        end else begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = {alu_result[XLEN-1:2], 2'b00};
                            lf3_d      = funct3;
                            lrd_d      = rd;
                            loff_d     = alu_result[1:0];
                            cnt_d      = '0;
                            state_d    = WAIT;
                        end
                    end else if (writes_rd(opcode) && rd != 5'd0) begin
                        rf_we_d = 1'b1;
                        waddr_d = rd;
                        wdata_d = (opcode == OP_JAL || opcode == OP_JALR) ?
                                  pc + XLEN'(4) : alu_result;
                    end
                end
            end
            WAIT: begin
                // A response on the limit cycle wins over the timeout.
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (lrd_q != 5'd0) begin
                        rf_we_d = 1'b1;
                        waddr_d = lrd_q;
                        wdata_d = al_data;
                    end
                end else if (cnt_q + TO_W'(1) == TO_LIM) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lf3_q        <= '0;
            lrd_q        <= '0;
            loff_q       <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lf3_q        <= lf3_d;
            lrd_q        <= lrd_d;
            loff_q       <= loff_d;
            mem_req      <= mem_req_d;
            mem_addr     <= mem_addr_d;
            rf_we        <= rf_we_d;
            rf_waddr     <= waddr_d;
            rf_wdata     <= wdata_d;
            misalign_err <= mis_d;
            timeout_err  <= to_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage with hand-computed expectations.
module tb_wb_stage;
    import rv_pkg::*;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result, pc;
    logic        mem_req;
    logic [31:0] mem_addr, mem_rdata;
    logic        mem_rvalid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        misalign_err, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    wb_stage #(.XLEN(32), .MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .funct3       (funct3),
        .rd           (rd),
        .alu_result   (alu_result),
        .pc           (pc),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] alu, input logic [31:0] p);
        in_valid   = 1'b1;
        opcode     = op;
        funct3     = f3;
        rd         = r;
        alu_result = alu;
        pc         = p;
        tick();
        in_valid = 1'b0;
    endtask

    // Load answered on the third cycle after acceptance.
    task automatic load_rsp(input string tag, input logic [2:0] f3, input logic [4:0] r,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] expd);
        issue(OP_LOAD, f3, r, addr, 32'h0);
        chk({tag, ".req"}, {31'b0, mem_req}, 32'd1);
        chk({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".rdy0"}, {31'b0, in_ready}, 32'd0);
        tick();
        chk({tag, ".req_once"}, {31'b0, mem_req}, 32'd0);
        chk({tag, ".rdy1"}, {31'b0, in_ready}, 32'd0);
        tick();
        chk({tag, ".rdy2"}, {31'b0, in_ready}, 32'd0);
        mem_rdata  = rdata;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk({tag, ".we"}, {31'b0, rf_we}, 32'd1);
        chk({tag, ".waddr"}, {27'b0, rf_waddr}, {27'b0, r});
        chk({tag, ".wdata"}, rf_wdata, expd);
        chk({tag, ".rdy_back"}, {31'b0, in_ready}, 32'd1);
        tick();
        chk({tag, ".we_once"}, {31'b0, rf_we}, 32'd0);
    endtask

    initial begin
        logic bad;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        opcode     = '0;
        funct3     = '0;
        rd         = '0;
        alu_result = '0;
        pc         = '0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        #2;
        chk("rst.rdy", {31'b0, in_ready}, 32'd0);
        chk("rst.we", {31'b0, rf_we}, 32'd0);
        chk("rst.req", {31'b0, mem_req}, 32'd0);
        chk("rst.to", {31'b0, timeout_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst.rdy_rel", {31'b0, in_ready}, 32'd1);

        // Back-to-back R-types
        issue(OP_R, 3'b000, 5'd5, 32'h0000_00AA, 32'h0);
        chk("r1.we", {31'b0, rf_we}, 32'd1);
        chk("r1.waddr", {27'b0, rf_waddr}, 32'd5);
        chk("r1.wdata", rf_wdata, 32'h0000_00AA);
        chk("r1.rdy", {31'b0, in_ready}, 32'd1);
        issue(OP_R, 3'b000, 5'd6, 32'h0000_00BB, 32'h0);
        chk("r2.we", {31'b0, rf_we}, 32'd1);
        chk("r2.waddr", {27'b0, rf_waddr}, 32'd6);
        chk("r2.wdata", rf_wdata, 32'h0000_00BB);
        tick();
        chk("r2.we_once", {31'b0, rf_we}, 32'd0);

        issue(OP_JAL, 3'b000, 5'd1, 32'hDEAD_BEEF, 32'h0000_0100);
        chk("jal.we", {31'b0, rf_we}, 32'd1);
        chk("jal.wdata", rf_wdata, 32'h0000_0104);
        issue(OP_JALR, 3'b000, 5'd2, 32'h0, 32'hFFFF_FFFC);
        chk("jalr.wrap", rf_wdata, 32'h0000_0000);
        issue(OP_LUI, 3'b000, 5'd3, 32'h1234_5000, 32'h0);
        chk("lui.wdata", rf_wdata, 32'h1234_5000);
        issue(OP_IMM, 3'b000, 5'd0, 32'h0000_0055, 32'h0);
        chk("addi_x0.we", {31'b0, rf_we}, 32'd0);
        issue(7'b1100011, 3'b000, 5'd4, 32'h0000_0066, 32'h0);
        chk("branch.we", {31'b0, rf_we}, 32'd0);
        chk("branch.rdy", {31'b0, in_ready}, 32'd1);

        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("idle_rvalid.we", {31'b0, rf_we}, 32'd0);

        load_rsp("lb",  F3_LB,  5'd7,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
        load_rsp("lbu", F3_LBU, 5'd7,  32'h0000_1003, 32'h80FF_1234, 32'h0000_0080);
        load_rsp("lh",  F3_LH,  5'd8,  32'h0000_1002, 32'h8001_0000, 32'hFFFF_8001);
        load_rsp("lhu", F3_LHU, 5'd8,  32'h0000_1001, 32'h00A5_C300, 32'h0000_A5C3);
        load_rsp("lw",  F3_LW,  5'd9,  32'h0000_2000, 32'hCAFE_F00D, 32'hCAFE_F00D);

        issue(OP_LOAD, F3_LW, 5'd9, 32'h0000_1001, 32'h0);
        chk("lw_mis.err", {31'b0, misalign_err}, 32'd1);
        chk("lw_mis.req", {31'b0, mem_req}, 32'd0);
        chk("lw_mis.we", {31'b0, rf_we}, 32'd0);
        chk("lw_mis.rdy", {31'b0, in_ready}, 32'd1);
        tick();
        chk("lw_mis.pulse", {31'b0, misalign_err}, 32'd0);
        issue(OP_LOAD, F3_LH, 5'd9, 32'h0000_1003, 32'h0);
        chk("lh_mis.err", {31'b0, misalign_err}, 32'd1);
        issue(OP_LOAD, 3'b011, 5'd9, 32'h0000_1000, 32'h0);
        chk("f3_011.err", {31'b0, misalign_err}, 32'd1);
        chk("f3_011.req", {31'b0, mem_req}, 32'd0);

        // Response on the final permitted wait cycle
        issue(OP_LOAD, F3_LW, 5'd11, 32'h0000_3000, 32'h0);
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (in_ready !== 1'b0 || rf_we !== 1'b0) bad = 1'b1;
            tick();
        end
        chk("edge.waiting", {31'b0, bad | in_ready}, 32'd0);
        mem_rdata  = 32'h0BAD_CAFE;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("edge.we", {31'b0, rf_we}, 32'd1);
        chk("edge.wdata", rf_wdata, 32'h0BAD_CAFE);
        chk("edge.to", {31'b0, timeout_err}, 32'd0);

        // Withheld response
        issue(OP_LOAD, F3_LW, 5'd12, 32'h0000_4000, 32'h0);
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (in_ready !== 1'b0 || timeout_err !== 1'b0) bad = 1'b1;
            tick();
        end
        chk("to.waiting", {31'b0, bad | in_ready | timeout_err}, 32'd0);
        tick();
        chk("to.err", {31'b0, timeout_err}, 32'd1);
        chk("to.we", {31'b0, rf_we}, 32'd0);
        chk("to.rdy", {31'b0, in_ready}, 32'd1);
        issue(OP_R, 3'b000, 5'd10, 32'h0000_1234, 32'h0);
        chk("to_add.we", {31'b0, rf_we}, 32'd1);
        chk("to_add.wdata", rf_wdata, 32'h0000_1234);
        chk("to.sticky", {31'b0, timeout_err}, 32'd1);

        // Reset during WAIT
        issue(OP_LOAD, F3_LW, 5'd13, 32'h0000_5000, 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstw.rdy", {31'b0, in_ready}, 32'd0);
        chk("rstw.req", {31'b0, mem_req}, 32'd0);
        chk("rstw.addr", mem_addr, 32'h0);
        chk("rstw.we", {31'b0, rf_we}, 32'd0);
        chk("rstw.wdata", rf_wdata, 32'h0);
        chk("rstw.to", {31'b0, timeout_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        mem_rdata  = 32'h1111_2222;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("rstw.late_we", {31'b0, rf_we}, 32'd0);
        tick();
        chk("rstw.late_we2", {31'b0, rf_we}, 32'd0);
        chk("rstw.rdy_back", {31'b0, in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
